// File: rtl/ysyx_22050019_pipe_stage_if.sv
// ysyx_22050019_pipe_stage_if : valid/ready beat bundle (payload, commit bit, debug sideband)
// rev 1.0
`default_nettype none

interface ysyx_22050019_pipe_stage_if #(
   parameter int DATA_W = 256,
   parameter int DBG_W  = 96
);
   logic              valid;
   logic              ready;
   logic [DATA_W-1:0] data;
   logic              commit;
   logic [DBG_W-1:0]  dbg;

   modport master (output valid, data, commit, dbg, input ready);
   modport slave  (input valid, data, commit, dbg, output ready);
endinterface

`default_nettype wire

// File: rtl/ysyx_22050019_pipe_stage.sv
// ysyx_22050019_pipe_stage : valid/ready pipeline register with optional skid entry and bubble counter
// rev 1.0
`default_nettype none

module ysyx_22050019_pipe_stage #(
   parameter int DATA_W      = 256,
   parameter int DBG_W       = 96,
   parameter int SKID        = 1,
   parameter int ZERO_BUBBLE = 1,
   parameter int CNT_W       = 32
) (
   input  logic                         clk,
   input  logic                         rst_n,
   ysyx_22050019_pipe_stage_if.slave    up_i,
   ysyx_22050019_pipe_stage_if.master   dn_o,
   input  logic                         flush_i,
   output logic [1:0]                   occupancy_o,
   output logic [CNT_W-1:0]             bubble_cnt_o
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic [DATA_W-1:0]   main_data_q, main_data_d;
   logic                main_commit_q, main_commit_d;
   logic [DATA_W-1:0]   skid_data_q, skid_data_d;
   logic                skid_commit_q, skid_commit_d;
   logic [DBG_W-1:0]    skid_dbg_q, skid_dbg_d;
   logic [DBG_W-1:0]    dbg_q, dbg_d;
   logic [CNT_W-1:0]    bubble_q, bubble_d;

   logic main_valid;
   logic in_ready;
   logic acc_in;
   logic acc_out;

   assign main_valid = (state_q != ST_EMPTY);

   // Skid mode decodes ready from state flops only, cutting the out_ready->in_ready path.
   generate
      if (SKID != 0) begin : g_ready_skid
         assign in_ready = !rst_n && (state_q != ST_FULL);
      end else begin : g_ready_comb
         assign in_ready = !rst_n && (!main_valid || dn_o.ready);
      end
   endgenerate

   assign up_i.ready = in_ready;
   assign acc_in     = up_i.valid && in_ready;
   assign acc_out    = main_valid && dn_o.ready;

   always_comb begin
      state_d       = state_q;
      main_data_d   = main_data_q;
      main_commit_d = main_commit_q;
      skid_data_d   = skid_data_q;
      skid_commit_d = skid_commit_q;
      skid_dbg_d    = skid_dbg_q;
      dbg_d         = dbg_q;
      bubble_d      = bubble_q;

      if (dn_o.ready && !main_valid && !flush_i && (bubble_q != '1)) begin
         bubble_d = bubble_q + CNT_W'(1);
      end

      if (flush_i) begin
         state_d = ST_EMPTY;
         dbg_d   = up_i.dbg;
      end else begin
         unique case (state_q)
            ST_EMPTY: begin
               if (acc_in) begin
                  state_d       = ST_ONE;
                  main_data_d   = up_i.data;
                  main_commit_d = up_i.commit;
                  dbg_d         = up_i.dbg;
               end
            end
            ST_ONE: begin
               // Without a skid entry an accept here always coincides with a drain.
               if (acc_in && (acc_out || SKID == 0)) begin
                  main_data_d   = up_i.data;
                  main_commit_d = up_i.commit;
                  dbg_d         = up_i.dbg;
               end else if (acc_in) begin
                  state_d       = ST_FULL;
                  skid_data_d   = up_i.data;
                  skid_commit_d = up_i.commit;
                  skid_dbg_d    = up_i.dbg;
               end else if (acc_out) begin
                  state_d = ST_EMPTY;
               end
            end
            ST_FULL: begin
               if (acc_out) begin
                  state_d       = ST_ONE;
                  main_data_d   = skid_data_q;
                  main_commit_d = skid_commit_q;
                  dbg_d         = skid_dbg_q;
               end
            end
            default: state_d = ST_EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n) begin
         state_q       <= ST_EMPTY;
         main_data_q   <= '0;
         main_commit_q <= 1'b0;
         skid_data_q   <= '0;
         skid_commit_q <= 1'b0;
         skid_dbg_q    <= '0;
         dbg_q         <= '0;
         bubble_q      <= '0;
      end else begin
         state_q       <= state_d;
         main_data_q   <= main_data_d;
         main_commit_q <= main_commit_d;
         skid_data_q   <= skid_data_d;
         skid_commit_q <= skid_commit_d;
         skid_dbg_q    <= skid_dbg_d;
         dbg_q         <= dbg_d;
         bubble_q      <= bubble_d;
      end
   end

   generate
      if (ZERO_BUBBLE != 0) begin : g_zero_bubble
         assign dn_o.data = main_valid ? main_data_q : '0;
      end else begin : g_hold_data
         assign dn_o.data = main_data_q;
      end
   endgenerate

   assign dn_o.valid   = main_valid;
   assign dn_o.commit  = main_valid && main_commit_q;
   assign dn_o.dbg     = dbg_q;
   assign occupancy_o  = state_q;
   assign bubble_cnt_o = bubble_q;

endmodule

`default_nettype wire

// File: tb/tb_ysyx_22050019_pipe_stage.sv
// tb_ysyx_22050019_pipe_stage : two stage variants (skid+zero-bubble, plain+hold) vs a beat-queue model
// rev 1.0
`default_nettype none

module tb_ysyx_22050019_pipe_stage;
   localparam int DW = 16;
   localparam int GW = 32;
   localparam int CW = 4;

   logic clk = 1'b0;
   logic rst_n;
   logic flush;
   always #5 clk = ~clk;

   ysyx_22050019_pipe_stage_if #(.DATA_W(DW), .DBG_W(GW)) up_a ();
   ysyx_22050019_pipe_stage_if #(.DATA_W(DW), .DBG_W(GW)) dn_a ();
   ysyx_22050019_pipe_stage_if #(.DATA_W(DW), .DBG_W(GW)) up_b ();
   ysyx_22050019_pipe_stage_if #(.DATA_W(DW), .DBG_W(GW)) dn_b ();

   logic [1:0]    occ_a, occ_b;
   logic [CW-1:0] bub_a, bub_b;

   ysyx_22050019_pipe_stage #(.DATA_W(DW), .DBG_W(GW), .SKID(1), .ZERO_BUBBLE(1), .CNT_W(CW)) dut_a (
      .clk(clk), .rst_n(rst_n), .up_i(up_a), .dn_o(dn_a), .flush_i(flush),
      .occupancy_o(occ_a), .bubble_cnt_o(bub_a));

   ysyx_22050019_pipe_stage #(.DATA_W(DW), .DBG_W(GW), .SKID(0), .ZERO_BUBBLE(0), .CNT_W(CW)) dut_b (
      .clk(clk), .rst_n(rst_n), .up_i(up_b), .dn_o(dn_b), .flush_i(flush),
      .occupancy_o(occ_b), .bubble_cnt_o(bub_b));

   logic [1:0]    act_valid, act_commit, act_rdy;
   logic [DW-1:0] act_data [2];
   logic [GW-1:0] act_dbg  [2];
   logic [1:0]    act_occ  [2];
   logic [CW-1:0] act_bub  [2];
   assign act_valid  = {dn_b.valid, dn_a.valid};
   assign act_commit = {dn_b.commit, dn_a.commit};
   assign act_rdy    = {up_b.ready, up_a.ready};
   assign act_data[0] = dn_a.data;  assign act_data[1] = dn_b.data;
   assign act_dbg[0]  = dn_a.dbg;   assign act_dbg[1]  = dn_b.dbg;
   assign act_occ[0]  = occ_a;      assign act_occ[1]  = occ_b;
   assign act_bub[0]  = bub_a;      assign act_bub[1]  = bub_b;

   // Reference model: each stage is a FIFO of held beats with capacity 1 or 2.
   bit            skid_m [2] = '{1'b1, 1'b0};
   bit            zb_m   [2] = '{1'b1, 1'b0};
   string         nm     [2] = '{"skid", "plain"};
   int            cnt    [2];
   logic [DW-1:0] qd     [2][2];
   logic          qc     [2][2];
   logic [GW-1:0] qg     [2][2];
   logic [DW-1:0] last_d [2];
   logic [GW-1:0] last_g [2];
   int            bub    [2];
   logic          exp_rdy[2];

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         cnt[i] = 0; last_d[i] = '0; last_g[i] = '0; bub[i] = 0;
      end
   endtask

   task automatic step(input logic r, input logic v, input logic [DW-1:0] d, input logic c,
                       input logic [GW-1:0] g, input logic f, input logic ordy);
      logic popped, pushed;
      @(negedge clk);
      rst_n = r; flush = f;
      up_a.valid = v; up_a.data = d; up_a.commit = c; up_a.dbg = g;
      up_b.valid = v; up_b.data = d; up_b.commit = c; up_b.dbg = g;
      dn_a.ready = ordy; dn_b.ready = ordy;
      #1;
      for (int i = 0; i < 2; i++) begin
         exp_rdy[i] = !r && (skid_m[i] ? (cnt[i] < 2) : (cnt[i] == 0 || ordy));
         check({nm[i], ".in_ready"},  64'(act_rdy[i]),   64'(exp_rdy[i]));
         check({nm[i], ".out_valid"}, 64'(act_valid[i]), 64'(cnt[i] > 0));
         check({nm[i], ".out_data"},  64'(act_data[i]),
               64'((cnt[i] > 0) ? qd[i][0] : (zb_m[i] ? '0 : last_d[i])));
         check({nm[i], ".out_commit"}, 64'(act_commit[i]), 64'((cnt[i] > 0) && qc[i][0]));
         check({nm[i], ".out_dbg"},   64'(act_dbg[i]), 64'(last_g[i]));
         check({nm[i], ".occupancy"}, 64'(act_occ[i]), 64'(cnt[i]));
         check({nm[i], ".bubble_cnt"}, 64'(act_bub[i]), 64'(bub[i]));
      end
      @(posedge clk);
      if (r) begin
         model_reset();
      end else begin
         for (int i = 0; i < 2; i++) begin
            popped = (cnt[i] > 0) && ordy;
            pushed = v && exp_rdy[i] && !f;
            if (ordy && cnt[i] == 0 && !f && bub[i] < (2**CW - 1)) bub[i]++;
            if (f) begin
               cnt[i] = 0;
               last_g[i] = g;
            end else begin
               if (popped) begin
                  qd[i][0] = qd[i][1]; qc[i][0] = qc[i][1]; qg[i][0] = qg[i][1];
                  cnt[i]--;
               end
               if (pushed) begin
                  qd[i][cnt[i]] = d; qc[i][cnt[i]] = c; qg[i][cnt[i]] = g;
                  cnt[i]++;
               end
               if (cnt[i] > 0) begin
                  last_d[i] = qd[i][0];
                  last_g[i] = qg[i][0];
               end
            end
         end
      end
   endtask

   initial begin
      rst_n = 1'b1; flush = 1'b0;
      up_a.valid = 1'b1; up_a.data = '0; up_a.commit = 1'b0; up_a.dbg = '0;
      up_b.valid = 1'b1; up_b.data = '0; up_b.commit = 1'b0; up_b.dbg = '0;
      dn_a.ready = 1'b0; dn_b.ready = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);

      // Reset held with a beat offered, then release.
      step(1, 1, 16'h55, 1, 32'h1, 0, 1);
      step(1, 1, 16'h55, 1, 32'h1, 0, 1);
      step(0, 0, 16'h00, 0, 32'h0, 0, 0);

      // Back-to-back stream with downstream always ready.
      step(0, 1, 16'h11, 1, 32'h100, 0, 1);
      step(0, 1, 16'h22, 0, 32'h200, 0, 1);
      step(0, 1, 16'h33, 1, 32'h300, 0, 1);
      step(0, 0, 16'h00, 0, 32'h0,   0, 1);
      step(0, 0, 16'h00, 0, 32'h0,   0, 1);

      // Backpressure: fill, stall, release.
      step(0, 1, 16'h0A, 1, 32'hA0, 0, 0);
      step(0, 1, 16'h0B, 1, 32'hB0, 0, 0);
      step(0, 1, 16'h0C, 1, 32'hC0, 0, 0);
      step(0, 1, 16'h0C, 1, 32'hC0, 0, 0);
      repeat (3) step(0, 1, 16'h0C, 1, 32'hC0, 0, 1);
      repeat (2) step(0, 0, 16'h00, 0, 32'h0, 0, 1);

      // Flush while full with a beat offered.
      step(0, 1, 16'h0A, 1, 32'hA1, 0, 0);
      step(0, 1, 16'h0B, 1, 32'hB1, 0, 0);
      step(0, 1, 16'h0D, 1, 32'hD1, 1, 0);
      repeat (2) step(0, 0, 16'h00, 0, 32'h0, 0, 1);

      // Single committed beat then drain into bubbles.
      step(0, 1, 16'h77, 1, 32'h80000004, 0, 1);
      repeat (4) step(0, 0, 16'h00, 0, 32'h0, 0, 1);

      // Counter saturation.
      repeat (20) step(0, 0, 16'h00, 0, 32'h0, 0, 1);

      // Random traffic including flushes, resets and flush+reset overlap.
      for (int k = 0; k < 400; k++) begin
         step(($urandom_range(0, 49) == 0),
              ($urandom_range(0, 9) < 6),
              DW'($urandom), 1'($urandom),
              GW'($urandom),
              ($urandom_range(0, 9) == 0),
              ($urandom_range(0, 9) < 6));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
